uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 164 ++++++++++++++++
 tb/tb_uart_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, stop.
// Define UART_TX_PARITY_EN to build the parity bit and the PARITY state.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [5:0]            presc_q, presc_d;
    logic [3:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  last;

`ifdef UART_TX_PARITY_EN
    logic pen_q, pen_d;
    logic par_q, par_d;
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    // Prescale of 0 wraps the compare value to 63, giving 64 cycles.
    assign last = (cnt_q == presc_q - 6'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 6'd1;
        presc_d = presc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
`ifdef UART_TX_PARITY_EN
        pen_d   = pen_q;
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (Data_Valid) begin
                    state_d = START;
                    presc_d = Prescale;
                    shift_d = P_DATA;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    pen_d   = PAR_EN;
                    par_d   = (^P_DATA) ^ PAR_TYP;
`endif
                end
            end
            START: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            DATA: begin
                if (last) begin
                    cnt_d = '0;
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
                        if (pen_q) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end
`endif
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            presc_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            pen_q   <= pen_d;
            par_q   <= par_d;
`endif
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: frames are predicted when driven and
// checked sample-by-sample when Busy falls.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] P_DATA = '0;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic       TX_OUT;
    logic       Busy;

    typedef struct {
        logic [15:0] bits;
        int          n;
        int          bt;
    } frame_t;

    frame_t sb_q[$];
    logic   samp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .P_DATA(P_DATA),
        .Data_Valid(Data_Valid), .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP), .Prescale(Prescale),
        .TX_OUT(TX_OUT), .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic sb_push(input logic [7:0] d, input logic pe,
                           input logic pt, input logic [5:0] ps);
        frame_t f;
        f.bits = '0;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
        f.n = 9;
        if (PAR_BUILD && pe) begin
            f.bits[f.n] = (^d) ^ pt;
            f.n++;
        end
        f.bits[f.n] = 1'b1;
        f.n++;
        f.bt = (ps == 6'd0) ? 64 : int'(ps);
        sb_q.push_back(f);
    endtask

    task automatic finish_frame();
        frame_t f;
        logic   obs;
        int     idx;
        if (sb_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
            return;
        end
        f = sb_q.pop_front();
        check("busy_len", samp_q.size(), f.n * f.bt);
        for (int i = 0; i < f.n; i++) begin
            obs = f.bits[i];
            for (int j = 0; j < f.bt; j++) begin
                idx = i * f.bt + j;
                if (idx >= samp_q.size()) obs = 1'bx;
                else if (samp_q[idx] !== f.bits[i]) obs = samp_q[idx];
            end
            check($sformatf("bit%0d", i), obs, f.bits[i]);
        end
    endtask

    initial begin
        int gap = 0;
        bit inf = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                samp_q.delete();
                inf = 0;
                gap++;
            end else if (Busy) begin
                if (!inf) begin
                    check("idle_gap", gap >= 1, 1);
                    inf = 1;
                end
                samp_q.push_back(TX_OUT);
            end else begin
                if (inf) begin
                    finish_frame();
                    samp_q.delete();
                    inf = 0;
                    gap = 0;
                end
                gap++;
                check("idle_tx", TX_OUT, 1);
            end
        end
    end

    task automatic wait_idle();
        @(posedge clk); #2;
        for (int i = 0; i < 1000 && Busy; i++) begin
            @(posedge clk); #2;
        end
        if (Busy) check("idle_timeout", Busy, 0);
    endtask

    task automatic drive(input logic [7:0] d, input logic pe,
                         input logic pt, input logic [5:0] ps);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
        Prescale = ps; Data_Valid = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic pe,
                        input logic pt, input logic [5:0] ps);
        wait_idle();
        drive(d, pe, pt, ps);
        sb_push(d, pe, pt, ps);
        @(posedge clk); #2;
        Data_Valid = 1'b0;
        check("accept_busy", Busy, 1);
        check("accept_tx", TX_OUT, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_tx", TX_OUT, 1);
        check("rst_busy", Busy, 0);
        rst = 1'b1;

        send(8'hA5, 1'b1, 1'b0, 6'd8);
        send(8'hFF, 1'b0, 1'b0, 6'd16);
        send(8'h01, 1'b1, 1'b1, 6'd5);
        send(8'h03, 1'b1, 1'b1, 6'd5);
        send(8'h00, 1'b0, 1'b0, 6'd0);

        // Data_Valid held through a frame with new inputs applied mid-frame
        wait_idle();
        drive(8'hA5, 1'b1, 1'b0, 6'd8);
        sb_push(8'hA5, 1'b1, 1'b0, 6'd8);
        @(posedge clk); #2;
        check("hold_accept", Busy, 1);
        repeat (3) @(posedge clk);
        #2;
        drive(8'h3C, 1'b1, 1'b1, 6'd4);
        sb_push(8'h3C, 1'b1, 1'b1, 6'd4);
        for (int i = 0; i < 200 && Busy; i++) begin
            @(posedge clk); #2;
        end
        check("hold_busy_fall", Busy, 0);
        @(posedge clk); #2;
        Data_Valid = 1'b0;
        check("hold_reaccept", Busy, 1);

        // reset during data bit 3
        wait_idle();
        drive(8'hA5, 1'b0, 1'b0, 6'd8);
        @(posedge clk); #2;
        Data_Valid = 1'b0;
        repeat (34) @(posedge clk);
        #2;
        check("bit3_pre_rst", TX_OUT, 0);
        rst = 1'b0;
        #1;
        check("async_rst_tx", TX_OUT, 1);
        check("async_rst_busy", Busy, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        drive(8'h55, 1'b0, 1'b0, 6'd8);
        sb_push(8'h55, 1'b0, 1'b0, 6'd8);
        @(posedge clk); #2;
        Data_Valid = 1'b0;
        check("first_edge_accept", Busy, 1);
        check("first_edge_tx", TX_OUT, 0);

        wait_idle();
        repeat (3) @(posedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
